// File: rtl/i_mem_ctrl.sv
// Instruction memory with a sequential program loader (valid/ready) and a registered fetch port (req/valid).
// Optional fault detection on misaligned/out-of-range addresses when I_MEM_FAULT_EN is defined.
module i_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDR_WIDTH-1:0]    fetch_addr,
  output logic                     fetch_ready,
  output logic [DATA_WIDTH-1:0]    inst,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  input  logic                     load_start,
  input  logic [ADDR_WIDTH-1:0]    load_base,
  input  logic                     load_valid,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_done,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     fetch_fault
);
  localparam int BO = $clog2(DATA_WIDTH/8);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  vld_q, vld_d;
  logic                  flt_q, flt_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IW-1:0] fidx, lidx;
  logic          misal, oor_f, oor_l, f_bad, l_bad, fire, wr_en;
  logic          unused_bits;

  assign fidx = fetch_addr[BO+IW-1:BO];
  assign lidx = load_base[BO+IW-1:BO];

  generate
    if (BO > 0) begin : g_lo
      assign misal = |fetch_addr[BO-1:0];
    end else begin : g_nlo
      assign misal = 1'b0;
    end
    if (ADDR_WIDTH > BO + IW) begin : g_hi
      assign oor_f = |fetch_addr[ADDR_WIDTH-1:BO+IW];
      assign oor_l = |load_base[ADDR_WIDTH-1:BO+IW];
    end else begin : g_nhi
      assign oor_f = 1'b0;
      assign oor_l = 1'b0;
    end
  endgenerate

`ifdef I_MEM_FAULT_EN
  assign f_bad = misal | oor_f;
  assign l_bad = oor_l;
`else
  // Without fault detection, offset and upper address bits are don't-care (addresses alias).
  assign f_bad = 1'b0;
  assign l_bad = 1'b0;
`endif
  assign unused_bits = ^{load_base, misal, oor_f, oor_l};

  assign fetch_ready = (state_q == S_IDLE) && (!vld_q || inst_ready);
  assign fire        = fetch_req && fetch_ready;
  assign load_ready  = (state_q == S_LOAD);
  assign load_done   = (state_q == S_DONE);
  assign wr_en       = load_ready && load_valid;

  assign inst        = inst_q;
  assign inst_valid  = vld_q;
  assign load_count  = cnt_q;
  assign fetch_fault = flt_q;

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= load_data;
  end

  always_comb begin
    inst_d = inst_q;
    vld_d  = vld_q;
    flt_d  = flt_q;
    if (fire) begin
      vld_d  = 1'b1;
      flt_d  = f_bad;
      inst_d = f_bad ? '0 : mem_q[fidx];
    end else if (vld_q && inst_ready) begin
      vld_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (load_start) begin
        ptr_d   = lidx;
        cnt_d   = '0;
        state_d = l_bad ? S_DONE : S_LOAD;
      end
      S_LOAD: if (load_valid) begin
        ptr_d = ptr_q + 1'b1;
        cnt_d = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
        if (load_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      vld_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      vld_q   <= vld_d;
      flt_q   <= flt_d;
    end
  end
endmodule

// File: tb/tb_i_mem_ctrl.sv
// Directed bench for i_mem_ctrl (DEPTH=16): cycle-level reference model plus hand-computed literal checks.
module tb_i_mem_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef I_MEM_FAULT_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ready;
  logic [DW-1:0] inst;
  logic          inst_valid;
  logic          inst_ready = 1'b1;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          load_done;
  logic [CW-1:0] load_count;
  logic          fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  i_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_done(load_done), .load_count(load_count), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec rules with word arithmetic (addr/4 mod DEPTH).
  int          m_mode;   // 0 idle, 1 loading, 2 done
  int          m_ptr, m_cnt;
  logic        m_valid, m_fault;
  logic [31:0] m_inst;
  logic [31:0] mm [DEPTH];

  function automatic bit bad_fetch(input logic [31:0] a);
    return FAULT && ((a % 4) != 0 || a >= DEPTH * 4);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0; m_ptr <= 0; m_cnt <= 0;
      m_valid <= 1'b0; m_fault <= 1'b0; m_inst <= '0;
    end else begin
      if (m_mode == 0 && fetch_req && (!m_valid || inst_ready)) begin
        m_valid <= 1'b1;
        m_fault <= bad_fetch(fetch_addr);
        m_inst  <= bad_fetch(fetch_addr) ? 32'h0 : mm[(fetch_addr / 4) % DEPTH];
      end else if (m_valid && inst_ready) begin
        m_valid <= 1'b0;
      end
      case (m_mode)
        0: if (load_start) begin
          m_cnt  <= 0;
          m_ptr  <= (load_base / 4) % DEPTH;
          m_mode <= (FAULT && load_base >= DEPTH * 4) ? 2 : 1;
        end
        1: if (load_valid) begin
          mm[m_ptr] <= load_data;
          m_ptr <= (m_ptr + 1) % DEPTH;
          m_cnt <= (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
          if (load_last) m_mode <= 2;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("fetch_ready", 32'(fetch_ready), 32'(m_mode == 0 && (!m_valid || inst_ready)));
      chk("load_ready",  32'(load_ready),  32'(m_mode == 1));
      chk("load_done",   32'(load_done),   32'(m_mode == 2));
      chk("load_count",  32'(load_count),  32'(m_cnt));
      chk("inst_valid",  32'(inst_valid),  32'(m_valid));
      chk("inst",        inst,             m_inst);
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Start a session, stream n words (seed+i), last flag on the final one; checks the done pulse.
  task automatic do_load(input logic [31:0] base, input int n, input logic [31:0] seed,
                         input int exp_cnt, input string name);
    load_start = 1'b1; load_base = base;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < n && load_ready; i++) begin
      load_valid = 1'b1; load_data = seed + 32'(i); load_last = (i == n - 1);
      cycle();
    end
    load_valid = 1'b0; load_last = 1'b0;
    @(negedge clk);
    chk({name, "_done"}, 32'(load_done), 32'd1);
    chk({name, "_cnt"}, 32'(load_count), 32'(exp_cnt));
    cycle();
  endtask

  task automatic fetch1(input logic [31:0] a, input logic [31:0] exp_i, input logic exp_f,
                        input string name);
    fetch_req = 1'b1; fetch_addr = a;
    cycle();
    fetch_req = 1'b0;
    @(negedge clk);
    chk({name, "_inst"}, inst, exp_i);
    chk({name, "_flt"}, 32'(fetch_fault), 32'(exp_f));
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_cnt", 32'(load_count), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_flt", 32'(fetch_fault), 32'd0);
    cycle();
    rst = 1'b1;
    cycle();

    // Fill all words; 17 words saturates the count at DEPTH and wraps to rewrite word 0
    do_load(32'h0, 17, 32'h100, 16, "full");
    fetch1(32'h0, 32'h110, 1'b0, "full0");
    fetch1(32'h8, 32'h102, 1'b0, "full2");

    // Reset in the middle of a session
    load_start = 1'b1; load_base = 32'h0;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 32'h55 + 32'(i) * 32'h11;
      cycle();
    end
    load_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cnt", 32'(load_count), 32'd0);
    chk("midrst_ready", 32'(load_ready), 32'd0);
    cycle();
    rst = 1'b1;
    cycle(); cycle();
    fetch1(32'h0, 32'h55, 1'b0, "midrst_m0");
    fetch1(32'h4, 32'h66, 1'b0, "midrst_m1");

    // Basic load
    do_load(32'h10, 3, 32'hA, 3, "basic");

    // Back-to-back fetches
    fetch_req = 1'b1; fetch_addr = 32'h14;
    cycle();
    fetch_addr = 32'h18;
    @(negedge clk);
    chk("b2b_inst0", inst, 32'hB);
    chk("b2b_vld0", 32'(inst_valid), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("b2b_inst1", inst, 32'hC);
    chk("b2b_vld1", 32'(inst_valid), 32'd1);
    cycle();

    // Backpressure
    inst_ready = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h10;
    cycle();
    fetch_addr = 32'h18;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_inst", inst, 32'hA);
      chk("bp_fready", 32'(fetch_ready), 32'd0);
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(fetch_ready), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("bp_next", inst, 32'hC);
    cycle();

    // Pointer wrap from the last word to word 0
    do_load(32'h3C, 2, 32'h1, 2, "wrap");
    fetch1(32'h3C, 32'h1, 1'b0, "wrap_m15");
    fetch1(32'h0, 32'h2, 1'b0, "wrap_m0");

    // Out-of-range / misaligned addresses: fault or alias
    fetch1(32'h40, FAULT ? 32'h0 : 32'h2, FAULT, "oor_fetch");
    fetch1(32'h2, FAULT ? 32'h0 : 32'h2, FAULT, "mis_fetch");
    do_load(32'h44, 1, 32'h77, FAULT ? 0 : 1, "oor_load");
    fetch1(32'h4, FAULT ? 32'h66 : 32'h77, 1'b0, "oor_m1");

    // Fetch and load_start together; pending result held through the session
    inst_ready = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h14;
    load_start = 1'b1; load_base = 32'h20;
    cycle();
    fetch_req = 1'b0; load_start = 1'b0;
    @(negedge clk);
    chk("sim_inst", inst, 32'hB);
    chk("sim_lready", 32'(load_ready), 32'd1);
    @(posedge clk); #1;
    load_valid = 1'b1; load_data = 32'h99; load_last = 1'b1;
    cycle();
    load_valid = 1'b0; load_last = 1'b0;
    @(negedge clk);
    chk("sim_done", 32'(load_done), 32'd1);
    chk("sim_held", 32'(inst_valid), 32'd1);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    cycle();
    fetch1(32'h20, 32'h99, 1'b0, "sim_m8");

    cycle(); cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i_mem_ctrl.md
Name: i_mem_ctrl

Overview:
- Parametrised instruction memory for the single-cycle core. It replaces the fixed word-only instruction memory wrapper.
- Adds a sequential program loader with a valid/ready handshake and a registered fetch port with a request/valid handshake.
- Adds optional fault detection.
- Sits between the PC/fetch logic and the decode stage; the loader is driven by the testbench or a boot controller.

Parameters:
ADDR_WIDTH, 32, width of byte addresses on fetch_addr and load_base
DATA_WIDTH, 32, instruction word width; must be a multiple of 8
DEPTH, 1024, number of words; must be a power of two

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  asynchronous, active-low reset
fetch_req  input  1  fetch request
fetch_addr  input  ADDR_WIDTH  byte address to fetch
fetch_ready  output  1  fetch accepted this cycle when fetch_req is high
inst  output  DATA_WIDTH  fetched instruction
inst_valid  output  1  inst holds a valid result
inst_ready  input  1  consumer takes inst
load_start  input  1  begin a load session at load_base
load_base  input  ADDR_WIDTH  byte start address of the load
load_valid  input  1  load_data is valid
load_data  input  DATA_WIDTH  word to write
load_last  input  1  marks the final word of the session
load_ready  output  1  loader accepts a word
load_done  output  1  one-cycle pulse when a session ends
load_count  output  $clog2(DEPTH)+1  words written in the current or last session
fetch_fault  output  1  fault flag accompanying inst_valid

Behaviour:
- Addressing
  - BO = $clog2(DATA_WIDTH/8).
  - Word index = addr[BO+$clog2(DEPTH)-1 : BO].
- Reset (rst=0, asynchronous)
  - State IDLE; inst=0, inst_valid=0, load_done=0, load_count=0, fetch_fault=0; internal write pointer=0.
  - Memory contents are not cleared.
  - Reset mid-load aborts the session immediately; words already written remain.
- Loader FSM: IDLE, LOAD, DONE.
  - IDLE -> LOAD on load_start. In that cycle: pointer <= word index of load_base, load_count <= 0.
  - LOAD
    - load_ready=1.
    - Each cycle with load_valid && load_ready: mem[pointer] <= load_data; pointer <= (pointer+1) mod DEPTH (wraps from DEPTH-1 to 0); load_count++ (saturates at DEPTH).
    - An accepted word with load_last=1 moves to DONE.
    - load_start is ignored in LOAD.
  - DONE: load_done=1 for exactly one cycle, load_ready=0, then IDLE.
  - load_ready=0 outside LOAD.
- Fetch
  - fetch_ready = (state==IDLE) && (!inst_valid || inst_ready).
  - Fetches are therefore blocked during LOAD and DONE, so there is no read/write collision.
  - Accepted fetch: next cycle inst <= mem[index], inst_valid <= 1. Latency is exactly 1 cycle.
  - Back-to-back fetches sustain one per cycle while inst_ready=1.
  - inst_valid && !inst_ready: inst and fetch_fault hold stable, no new fetch is accepted.
  - inst_valid && inst_ready && no new fetch: inst_valid <= 0; inst keeps its last value.
- Simultaneous events
  - load_start and fetch_req in the same IDLE cycle: the fetch is accepted (fetch_ready=1) and the load begins in the same edge.
  - A pending inst_valid is retained through LOAD until consumed.

Optional Feature:
Macro I_MEM_FAULT_EN.
- Defined: on an accepted fetch, fetch_fault <= 1 and inst <= 0 (instead of memory data) when either:
  - fetch_addr[BO-1:0] != 0 (misaligned), or
  - any fetch_addr bit above BO+$clog2(DEPTH)-1 is set (out of range).
  - Otherwise fetch_fault <= 0.
  - The same out-of-range check on load_base at load_start skips LOAD and goes straight to DONE with load_count=0.
- Undefined: fetch_fault is tied to 0; low offset bits and upper bits are ignored, so addresses alias modulo DEPTH words.

Test Plan:
- Reset mid-load: load_start with load_base=0x0, write 2 words, drop rst for 1 cycle -> state IDLE, load_count=0, load_done never pulses, mem[0..1] retain their written values.
- Basic load: load_start with load_base=0x10, then 3 words 0xA, 0xB, 0xC with load_last on the third -> load_done pulses 1 cycle after the third word, load_count=3, mem[4..6]=0xA, 0xB, 0xC.
- Fetch after load: fetch_addr=0x14, 0x18 on consecutive cycles with inst_ready=1 -> inst=0xB then 0xC, each 1 cycle after the request, inst_valid high for both cycles.
- Backpressure: fetch 0x10 with inst_ready=0 for 3 cycles -> inst=0xA held stable, fetch_ready=0 for those cycles; a new request is accepted on the cycle inst_ready=1.
- Wrap: DEPTH=16, load_base=0x3C, 2 words 0x1, 0x2 -> mem[15]=0x1, mem[0]=0x2, load_count=2.
- With I_MEM_FAULT_EN, DEPTH=1024: fetch 0x2 -> inst=0, fetch_fault=1; fetch 0x1000 -> fetch_fault=1. Without the macro, fetch 0x1000 returns mem[0] and fetch_fault=0.
